oam_dma: RTL and testbench
==========================

# oam_dma

Sprite DMA engine for the PPU's register interface. It decodes CPU writes to $4014 and halts the CPU. It then copies one 256-byte CPU page into OAM by issuing 256 OAMDATA ($2004) writes through the same chip-select/register-address path the CPU uses. It sits between the CPU bus and the PPU register interface, muxed onto that interface while `dma_active` is high.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014, CPU address that triggers DMA.
- `OAMDATA_IDX`, 3'd4, PPU register index driven during copy writes.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_ce`  in  1  one-clk strobe marking the end of each CPU bus cycle; all state advances only on `clk` edges with `cpu_ce`=1.
- `cpu_addr`  in  16  CPU address bus.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_we`  in  1  CPU write strobe.
- `cpu_rdy`  out  1  0 halts CPU.
- `dma_active`  out  1  1 selects DMA outputs onto memory and PPU buses.
- `mem_addr`  out  16  DMA read address.
- `mem_rd`  out  1  DMA read request.
- `mem_rdata`  in  8  read data, valid at the `cpu_ce` ending a read cycle.
- `ppu_cs_n`  out  1  PPU register chip select, active low.
- `ppu_reg_addr`  out  3  PPU register index.
- `ppu_we`  out  1  PPU register write.
- `ppu_wdata`  out  8  byte written to OAMDATA.

## Operation
States: IDLE, HALT, ALIGN, READ, WRITE.

- Trigger: in IDLE, a `cpu_ce` with `cpu_we`=1 and `cpu_addr`==`DMA_REG_ADDR` does two things:
  - latches `page` <= `cpu_wdata` and `idx` <= 0;
  - moves to HALT.
- HALT: lasts one CPU cycle (dummy); `cpu_rdy`=0 and `dma_active`=1.
  - Exit at its `cpu_ce`: to ALIGN if `parity`==1, else to READ.
- `parity`: 1-bit flop, reset 0, toggles on every `cpu_ce` in all states.
- ALIGN: one idle CPU cycle, then READ.
- READ:
  - drives `mem_addr`={`page`,`idx`} and `mem_rd`=1;
  - at `cpu_ce`, latches `mem_rdata` into `data_q` and moves to WRITE.
- WRITE:
  - drives `ppu_cs_n`=0, `ppu_reg_addr`=`OAMDATA_IDX`, `ppu_we`=1 and `ppu_wdata`=`data_q`;
  - at `cpu_ce`: if `idx`==255, go to IDLE, else `idx`<=`idx`+1 and go to READ.
- `ppu_cs_n` returns high during every READ, so the PPU sees a falling edge for each of the 256 writes.
- `idx` is 8 bits and wraps 255→0 only on termination. The source never crosses a page.
- Writes to `DMA_REG_ADDR` while not IDLE are ignored; `page` is not changed.
- Pages $20–$3F are not special-cased: reads go to the bus as-is.
- Output values outside the stated states:
  - `cpu_rdy`=1 and `dma_active`=0 only in IDLE;
  - `mem_rd`=0 outside READ;
  - `ppu_cs_n`=1, `ppu_we`=0 and `ppu_reg_addr`=0 outside WRITE.

## Timing
- Reset (asynchronous, `reset`=0):
  - state=IDLE, `cpu_rdy`=1, `dma_active`=0, `mem_rd`=0, `mem_addr`=0;
  - `ppu_cs_n`=1, `ppu_we`=0, `ppu_reg_addr`=0, `ppu_wdata`=0;
  - `page`=0, `idx`=0, `parity`=0.
- Reset mid-transfer aborts immediately: no further OAM writes and the CPU is released.
- All outputs are registered and change one `clk` after the `cpu_ce` edge that causes the transition.
- Length from trigger `cpu_ce` to the return to IDLE:
  - 513 CPU cycles with `parity`=0 at HALT exit;
  - 514 CPU cycles with `parity`=1 at HALT exit.
- With `cpu_ce` held at 0, all state and outputs hold.
- Simultaneous reset and trigger: reset wins.

## Configuration
- `OAM_DMA_ALIGN_EN` defined: ALIGN state and `parity` flop are built, giving 513/514-cycle transfers as above.
- `OAM_DMA_ALIGN_EN` undefined: no `parity` flop and no ALIGN state. HALT always goes to READ, and every transfer is 513 CPU cycles.

## Test plan
- `cpu_ce`=1, write $02 to $4014 with `parity`=0, memory byte i at $0200+i = i^8'hA5:
  - required: 256 `ppu_cs_n` falling edges with `ppu_reg_addr`=4;
  - byte k written = k^8'hA5;
  - `cpu_rdy` low for exactly 513 cycles.
- Same transfer triggered with `parity`=1 → `cpu_rdy` low for 514 cycles (513 with `OAM_DMA_ALIGN_EN` undefined).
- Second $4014 write ($07) issued at write #10 → ignored; all `mem_addr` values stay $02xx.
- `reset` pulsed low after write #100:
  - required same clk: `cpu_rdy`=1, `dma_active`=0, `ppu_cs_n`=1;
  - no writes follow.
- `cpu_ce` toggling every 3rd clk → same 256-byte sequence; each output level held for an integer number of CPU cycles; last write at `mem_addr`=$02FF.
- CPU reads from or writes to $4015 and $4013 → no trigger; `cpu_rdy` stays 1.

Source files
------------

// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - CPU, memory and PPU register bus bundle for the sprite DMA engine
//
// Purpose: groups the CPU bus inputs, DMA memory read port and PPU register
// write port that oam_dma sits between.
// Modports:
//   master - the DMA engine: samples CPU/memory inputs, drives halt, memory
//            read and PPU register outputs.
//   slave  - the surrounding system (CPU, memory, PPU register decode).
// Signals:
//   cpu_ce, cpu_addr[15:0], cpu_wdata[7:0], cpu_we  - CPU bus cycle and write
//   cpu_rdy, dma_active                             - CPU halt / bus mux select
//   mem_addr[15:0], mem_rd, mem_rdata[7:0]          - DMA source reads
//   ppu_cs_n, ppu_reg_addr[2:0], ppu_we, ppu_wdata  - OAMDATA writes
interface oam_dma_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        ppu_cs_n;
  logic [2:0]  ppu_reg_addr;
  logic        ppu_we;
  logic [7:0]  ppu_wdata;

  modport master (
    input  cpu_ce, cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    output cpu_rdy, dma_active, mem_addr, mem_rd,
           ppu_cs_n, ppu_reg_addr, ppu_we, ppu_wdata
  );

  modport slave (
    output cpu_ce, cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    input  cpu_rdy, dma_active, mem_addr, mem_rd,
           ppu_cs_n, ppu_reg_addr, ppu_we, ppu_wdata
  );
endinterface

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA: $4014 write halts the CPU and copies one page into OAM
//
// Purpose: decodes CPU writes to DMA_REG_ADDR, halts the CPU, then performs
// 256 read/write pairs: read {page, idx} from memory, write the byte to the
// PPU OAMDATA register through the PPU chip-select/register-address path.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   bus    - oam_dma_if.master (CPU bus in, halt/mux out, memory read port,
//            PPU register write port)
// Parameters:
//   DMA_REG_ADDR - CPU address that triggers a transfer
//   OAMDATA_IDX  - PPU register index used for every copy write
// Configuration macro:
//   OAM_DMA_ALIGN_EN - when defined, a parity flop and ALIGN state add one
//                      idle CPU cycle after HALT on odd cycles (513/514-cycle
//                      transfers); when undefined every transfer is 513 cycles.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_IDX  = 3'd4
) (
  input  logic      clk,
  input  logic      reset,
  oam_dma_if.master bus
);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  idx_next;
  logic [7:0]  data_q;
  logic        cpu_rdy_q;
  logic        dma_active_q;
  logic [15:0] mem_addr_q;
  logic        mem_rd_q;
  logic        ppu_cs_n_q;
  logic [2:0]  ppu_reg_addr_q;
  logic        ppu_we_q;
  logic        trigger;

  assign trigger  = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);
  assign idx_next = idx + 8'd1;

`ifdef OAM_DMA_ALIGN_EN
  // Tracks odd/even CPU cycles so reads can start on a fixed cycle parity.
  logic parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity <= 1'b0;
    end else if (bus.cpu_ce) begin
      parity <= ~parity;
    end
  end
`endif

  // Outputs are registered: each transition sets the output levels of the
  // state being entered, so they change on the same cpu_ce edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      page           <= 8'h00;
      idx            <= 8'h00;
      data_q         <= 8'h00;
      cpu_rdy_q      <= 1'b1;
      dma_active_q   <= 1'b0;
      mem_addr_q     <= 16'h0000;
      mem_rd_q       <= 1'b0;
      ppu_cs_n_q     <= 1'b1;
      ppu_reg_addr_q <= 3'd0;
      ppu_we_q       <= 1'b0;
    end else if (bus.cpu_ce) begin
      case (state)
        IDLE: begin
          if (trigger) begin
            page         <= bus.cpu_wdata;
            idx          <= 8'h00;
            state        <= HALT;
            cpu_rdy_q    <= 1'b0;
            dma_active_q <= 1'b1;
          end
        end
        HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          if (parity) begin
            state <= ALIGN;
          end else begin
            state      <= READ;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {page, idx};
          end
`else
          state      <= READ;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= {page, idx};
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        ALIGN: begin
          state      <= READ;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= {page, idx};
        end
`endif
        READ: begin
          data_q         <= bus.mem_rdata;
          mem_rd_q       <= 1'b0;
          ppu_cs_n_q     <= 1'b0;
          ppu_we_q       <= 1'b1;
          ppu_reg_addr_q <= OAMDATA_IDX;
          state          <= WRITE;
        end
        WRITE: begin
          // Chip select is released between writes so the PPU sees a
          // fresh falling edge for every byte.
          ppu_cs_n_q     <= 1'b1;
          ppu_we_q       <= 1'b0;
          ppu_reg_addr_q <= 3'd0;
          if (idx == 8'hFF) begin
            idx          <= 8'h00;
            state        <= IDLE;
            cpu_rdy_q    <= 1'b1;
            dma_active_q <= 1'b0;
          end else begin
            idx        <= idx_next;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {page, idx_next};
            state      <= READ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rdy      = cpu_rdy_q;
  assign bus.dma_active   = dma_active_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.ppu_cs_n     = ppu_cs_n_q;
  assign bus.ppu_reg_addr = ppu_reg_addr_q;
  assign bus.ppu_we       = ppu_we_q;
  assign bus.ppu_wdata    = data_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - randomized self-checking bench for oam_dma against a transfer-position model
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam int ALIGN_EN = 1;
`else
  localparam int ALIGN_EN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] mem_key;

  oam_dma_if bus ();

  // Memory image: byte at any address is its low address byte XOR mem_key.
  assign bus.mem_rdata = bus.mem_addr[7:0] ^ mem_key;

  oam_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: a transfer is a count of CPU cycles since the trigger.
  // Position 0 is the halt cycle, then an optional align cycle, then 512
  // cycles alternating read k / write k.
  logic       m_busy;
  logic [7:0] m_page;
  int         m_p;
  int         m_len;
  int         m_align;
  int         m_ce_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy   <= 1'b0;
      m_page   <= 8'h00;
      m_p      <= 0;
      m_len    <= 0;
      m_align  <= 0;
      m_ce_cnt <= 0;
    end else if (bus.cpu_ce) begin
      m_ce_cnt <= m_ce_cnt + 1;
      if (m_busy) begin
        m_p <= m_p + 1;
        if (m_p + 1 >= m_len) m_busy <= 1'b0;
      end else if (bus.cpu_we && bus.cpu_addr == 16'h4014) begin
        // Parity seen at halt exit = CPU cycles completed before that edge.
        m_busy  <= 1'b1;
        m_page  <= bus.cpu_wdata;
        m_p     <= 0;
        m_align <= ALIGN_EN * ((m_ce_cnt + 1) % 2);
        m_len   <= 513 + ALIGN_EN * ((m_ce_cnt + 1) % 2);
      end
    end
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  int         ce_period = 1;
  int         clk_cnt = 0;
  int         fall_cnt = 0;
  int         rdy_low = 0;
  int         bad_page = 0;
  logic       prev_cs_n = 1'b1;
  logic [15:0] last_rd_addr = 16'h0000;
  logic [7:0] scen_page = 8'h02;
  logic [7:0] cap_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare and monitor at the falling edge, then drive the
  // next cpu_ce just after the rising edge.
  task automatic tick();
    int   q;
    int   k;
    logic e_rd;
    logic e_wr;
    @(negedge clk);
    if (prev_cs_n && !bus.ppu_cs_n) begin
      fall_cnt++;
      cap_data.push_back(bus.ppu_wdata);
    end
    prev_cs_n = bus.ppu_cs_n;
    if (bus.mem_rd) begin
      last_rd_addr = bus.mem_addr;
      if (bus.mem_addr[15:8] != scen_page) bad_page++;
    end
    if (bus.cpu_ce && !bus.cpu_rdy) rdy_low++;

    e_rd = 1'b0;
    e_wr = 1'b0;
    k    = 0;
    if (m_busy) begin
      q = m_p - 1 - m_align;
      if (q >= 0) begin
        k    = q / 2;
        e_rd = (q % 2 == 0);
        e_wr = (q % 2 == 1);
      end
    end
    check("cpu_rdy", {31'd0, bus.cpu_rdy}, {31'd0, !m_busy});
    check("dma_active", {31'd0, bus.dma_active}, {31'd0, m_busy});
    check("mem_rd", {31'd0, bus.mem_rd}, {31'd0, e_rd});
    check("ppu_cs_n", {31'd0, bus.ppu_cs_n}, {31'd0, !e_wr});
    check("ppu_we", {31'd0, bus.ppu_we}, {31'd0, e_wr});
    check("ppu_reg_addr", {29'd0, bus.ppu_reg_addr}, e_wr ? 32'd4 : 32'd0);
    if (e_rd) check("mem_addr", {16'd0, bus.mem_addr}, {16'd0, m_page, k[7:0]});
    if (e_wr) check("ppu_wdata", {24'd0, bus.ppu_wdata}, {24'd0, k[7:0] ^ mem_key});

    @(posedge clk);
    #1;
    clk_cnt++;
    if (ce_period == 0) bus.cpu_ce = ($urandom_range(0, 1) == 1);
    else                bus.cpu_ce = ((clk_cnt % ce_period) == 0);
  endtask

  // want: 0/1 = required parity at halt exit, 2 = any cycle.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int want);
    int guard;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!(bus.cpu_ce && (want == 2 || ((m_ce_cnt + 1) % 2) == want)) && guard < 200);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_we    = 1'b1;
    tick();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0000;
  endtask

  task automatic do_read(input logic [15:0] a);
    int guard;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!bus.cpu_ce && guard < 200);
    bus.cpu_addr = a;
    bus.cpu_we   = 1'b0;
    tick();
    bus.cpu_addr = 16'h0000;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!bus.cpu_rdy && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, bus.cpu_rdy}, 32'd1);
  endtask

  task automatic wait_falls(input int base, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (fall_cnt - base < target && n < budget) begin
      tick();
      n++;
    end
    check(name, fall_cnt - base >= target, 32'd1);
  endtask

  task automatic check_bytes(input int base, input logic [7:0] key, input string name);
    logic [7:0] got;
    for (int k = 0; k < 256; k++) begin
      got = (base + k < cap_data.size()) ? cap_data[base + k] : 8'hxx;
      check(name, {24'd0, got}, {24'd0, 8'(k) ^ key});
    end
  endtask

  int b_fall;
  int b_low;
  int b_cap;
  int b_bad;

  task automatic snap();
    b_fall = fall_cnt;
    b_low  = rdy_low;
    b_cap  = cap_data.size();
    b_bad  = bad_page;
  endtask

  initial begin
    reset         = 1'b0;
    bus.cpu_ce    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
    mem_key       = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
    check("rst_dma_active", {31'd0, bus.dma_active}, 32'd0);
    check("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    check("rst_ppu_cs_n", {31'd0, bus.ppu_cs_n}, 32'd1);
    check("rst_ppu_we", {31'd0, bus.ppu_we}, 32'd0);
    check("rst_ppu_reg_addr", {29'd0, bus.ppu_reg_addr}, 32'd0);
    check("rst_ppu_wdata", {24'd0, bus.ppu_wdata}, 32'd0);
    reset = 1'b1;

    // Full-speed transfer of page $02, even parity at halt exit.
    ce_period = 1; scen_page = 8'h02; mem_key = 8'hA5;
    snap();
    do_write(16'h4014, 8'h02, 0);
    wait_idle(3000, "s1_done");
    check("s1_falls", fall_cnt - b_fall, 32'd256);
    check("s1_rdy_low", rdy_low - b_low, 32'd513);
    check_bytes(b_cap, 8'hA5, "s1_byte");
    check("s1_last_addr", {16'd0, last_rd_addr}, 32'h02FF);
    check("s1_page", bad_page - b_bad, 32'd0);

    // Odd parity at halt exit.
    snap();
    do_write(16'h4014, 8'h02, 1);
    wait_idle(3000, "s2_done");
    check("s2_falls", fall_cnt - b_fall, 32'd256);
    check("s2_rdy_low", rdy_low - b_low, ALIGN_EN ? 32'd514 : 32'd513);
    check_bytes(b_cap, 8'hA5, "s2_byte");

    // Second $4014 write mid-transfer is ignored.
    snap();
    do_write(16'h4014, 8'h02, 2);
    wait_falls(b_fall, 10, 200, "s3_reach10");
    do_write(16'h4014, 8'h07, 2);
    wait_idle(3000, "s3_done");
    check("s3_falls", fall_cnt - b_fall, 32'd256);
    check("s3_page", bad_page - b_bad, 32'd0);
    check("s3_last_addr", {16'd0, last_rd_addr}, 32'h02FF);
    check_bytes(b_cap, 8'hA5, "s3_byte");

    // Reset after write #100 aborts immediately.
    snap();
    do_write(16'h4014, 8'h02, 2);
    wait_falls(b_fall, 100, 1000, "s4_reach100");
    #1;
    reset = 1'b0;
    #1;
    check("s4_cpu_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
    check("s4_dma_active", {31'd0, bus.dma_active}, 32'd0);
    check("s4_ppu_cs_n", {31'd0, bus.ppu_cs_n}, 32'd1);
    check("s4_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    repeat (600) tick();
    check("s4_falls", fall_cnt - b_fall, 32'd100);
    check("s4_rdy", {31'd0, bus.cpu_rdy}, 32'd1);

    // cpu_ce every third clock.
    ce_period = 3;
    snap();
    do_write(16'h4014, 8'h02, 2);
    wait_idle(6000, "s5_done");
    check("s5_falls", fall_cnt - b_fall, 32'd256);
    check_bytes(b_cap, 8'hA5, "s5_byte");
    check("s5_last_addr", {16'd0, last_rd_addr}, 32'h02FF);
    check("s5_rdy_low_min", (rdy_low - b_low) >= 513, 32'd1);

    // Neighbouring registers and reads never trigger.
    ce_period = 1;
    snap();
    do_write(16'h4015, 8'h02, 2);
    do_write(16'h4013, 8'h02, 2);
    do_read(16'h4015);
    do_read(16'h4013);
    do_read(16'h4014);
    repeat (5) tick();
    check("s6_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
    check("s6_rdy_low", rdy_low - b_low, 32'd0);
    check("s6_falls", fall_cnt - b_fall, 32'd0);

    // Trigger during reset: reset wins.
    snap();
    bus.cpu_addr  = 16'h4014;
    bus.cpu_wdata = 8'h03;
    bus.cpu_we    = 1'b1;
    bus.cpu_ce    = 1'b1;
    reset         = 1'b0;
    tick();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0000;
    reset        = 1'b1;
    repeat (4) tick();
    check("s7_rdy", {31'd0, bus.cpu_rdy}, 32'd1);
    check("s7_rdy_low", rdy_low - b_low, 32'd0);

    // Randomized transfers: random page, data key, parity and cpu_ce pattern.
    for (int t = 0; t < 4; t++) begin
      ce_period = (t % 2 == 0) ? 0 : int'($urandom_range(1, 4));
      scen_page = 8'($urandom_range(0, 255));
      mem_key   = 8'($urandom_range(0, 255));
      snap();
      do_write(16'h4014, scen_page, int'($urandom_range(0, 1)));
      wait_idle(8000, "rnd_done");
      check("rnd_falls", fall_cnt - b_fall, 32'd256);
      check("rnd_page", bad_page - b_bad, 32'd0);
      check("rnd_last_addr", {16'd0, last_rd_addr}, {16'd0, scen_page, 8'hFF});
      check_bytes(b_cap, mem_key, "rnd_byte");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
